// File: rtl/stream_downsizer_if.sv
// -----------------------------------------------------------------------------
// stream_downsizer_if
//
// Bundles the two valid/ready streams of the width-down converter into one
// interface.
//
// Parameters:
//   IN_W   input word width (default 32)
//   OUT_W  output beat width (default 8)
//   CNT_W  derived width of the beat-count field, max(1, clog2(IN_W/OUT_W))
//
// Signals:
//   in_valid / in_ready   word handshake (producer -> converter)
//   in_data  [IN_W]       input word
//   in_cnt   [CNT_W]      number of valid beats minus one
//   in_last               word closes a packet
//   out_valid / out_ready beat handshake (converter -> consumer)
//   out_data [OUT_W]      output beat
//   out_last              final beat of a word that carried in_last
//
// Modports:
//   slave   the converter's view (accepts words, produces beats)
//   master  the environment's view (produces words, consumes beats)
// -----------------------------------------------------------------------------
interface stream_downsizer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = ($clog2(RATIO) < 1) ? 1 : $clog2(RATIO);

  // Word side
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [CNT_W-1:0] in_cnt;
  logic             in_last;

  // Beat side
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_cnt,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output in_cnt,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/stream_downsizer.sv
// -----------------------------------------------------------------------------
// stream_downsizer
//
// Width-down converter: accepts whole IN_W-bit words on a valid/ready stream
// and emits them as OUT_W-bit beats, one beat per cycle. Partial words (fewer
// than RATIO valid beats, given by in_cnt) and packet framing (in_last) are
// carried through. A new word is accepted in the same cycle the final beat of
// the current word transfers, so back-to-back words stream with no bubble.
//
// Parameters:
//   IN_W   input word width (default 32)
//   OUT_W  output beat width (default 8); IN_W must be a multiple of OUT_W and
//          IN_W/OUT_W must be at least 2
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; discards any word in flight
//   bus    stream_downsizer_if.slave carrying
//            in_valid/in_ready/in_data/in_cnt/in_last   (word side)
//            out_valid/out_ready/out_data/out_last      (beat side)
//
// Build option:
//   STREAM_DOWNSIZER_MSB_FIRST_EN
//     undefined: lane k = word[k*OUT_W +: OUT_W]            (LSB lane first)
//     defined:   lane k = word[(RATIO-1-k)*OUT_W +: OUT_W]  (MSB lane first)
// -----------------------------------------------------------------------------
module stream_downsizer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_downsizer_if.slave     bus
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = ($clog2(RATIO) < 1) ? 1 : $clog2(RATIO);

  // ---------------------------------------------------------------------------
  // Configuration sanity
  // ---------------------------------------------------------------------------
  if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_cfg
    $error("stream_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  word_q, word_d;   // holding register for the current word
  logic [CNT_W-1:0] idx_q,  idx_d;    // lane currently presented
  logic [CNT_W-1:0] cnt_q,  cnt_d;    // index of the final valid lane
  logic             last_q, last_d;   // current word closes a packet
  logic             busy_q, busy_d;   // a beat is being presented

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic final_idx;   // presented lane is the last one of the word
  logic beat_fire;   // a beat transfers this cycle
  logic word_fire;   // a word is accepted this cycle
  logic in_ready_w;

  assign final_idx = (idx_q == cnt_q);
  assign beat_fire = busy_q && bus.out_ready;

  // Ready when idle, or when the final beat is leaving this very cycle; this
  // lets the next word slot in behind the current one without a gap. It never
  // looks at in_valid, so there is no combinational valid->ready loop.
  assign in_ready_w = !busy_q || (bus.out_ready && final_idx);
  assign word_fire  = bus.in_valid && in_ready_w;

  // ---------------------------------------------------------------------------
  // Beat count capture
  // ---------------------------------------------------------------------------
  // For non-power-of-2 ratios the count field can encode values past the top
  // lane; those are clamped so idx_q never walks off the word. When the ratio
  // is a power of 2 every encoding is legal and the field passes straight in.
  logic [CNT_W-1:0] cnt_in;

  if ((1 << CNT_W) == RATIO) begin : g_cnt_direct
    assign cnt_in = bus.in_cnt;
  end else begin : g_cnt_clamp
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);
    assign cnt_in = (bus.in_cnt > CNT_MAX) ? CNT_MAX : bus.in_cnt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    busy_d = busy_q;

    if (word_fire) begin
      // Covers both the idle case and the final-beat-plus-new-word case;
      // in_ready guarantees no pending beat is overwritten.
      word_d = bus.in_data;
      cnt_d  = cnt_in;
      last_d = bus.in_last;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (beat_fire) begin
      if (final_idx) begin
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane mapping
  // ---------------------------------------------------------------------------
  // lane_w[k] is the k-th beat to be emitted. The output mux is driven only by
  // registers, so out_data is glitch-free with respect to the input stream and
  // stays put while the consumer stalls.
  logic [OUT_W-1:0] lane_w [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
    assign lane_w[gi] = word_q[(RATIO-1-gi)*OUT_W +: OUT_W];
`else
    assign lane_w[gi] = word_q[gi*OUT_W +: OUT_W];
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = busy_q;
  assign bus.out_data  = lane_w[idx_q];
  assign bus.out_last  = busy_q && last_q && final_idx;

endmodule

// File: tb/tb_stream_downsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_downsizer
//
// Directed bench for stream_downsizer (IN_W=32, OUT_W=8). Inputs change on the
// falling edge; outputs are sampled 1 time unit later, away from the rising
// edge. Expected beats are derived from the word with the lane order selected
// by STREAM_DOWNSIZER_MSB_FIRST_EN, so the same steps cover both builds.
// -----------------------------------------------------------------------------
module tb_stream_downsizer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stream_downsizer_if #(.IN_W(32), .OUT_W(8)) bus ();

  stream_downsizer #(.IN_W(32), .OUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Beat k of a word in the configured emission order.
  function automatic logic [7:0] lane(input logic [31:0] w, input int k);
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
    return w[(3-k)*8 +: 8];
`else
    return w[k*8 +: 8];
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] c,
                       input logic l, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_cnt    = c;
    bus.in_last   = l;
    bus.out_ready = r;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Check the beat side plus in_ready; data only matters while out_valid.
  task automatic expect_beat(input string tag, input logic v, input logic [7:0] d,
                             input logic l, input logic ir);
    chk_bit({tag, ".out_valid"}, bus.out_valid, v);
    if (v) chk_byte({tag, ".out_data"}, bus.out_data, d);
    chk_bit({tag, ".out_last"}, bus.out_last, l);
    chk_bit({tag, ".in_ready"}, bus.in_ready, ir);
    $display("step %-14s valid=%0b data=%02h last=%0b in_ready=%0b",
             tag, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
  endtask

  initial begin
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_p;
    w_a = 32'h4433_2211;
    w_b = 32'h8877_6655;
    w_p = 32'hDDCC_BBAA;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    #2;
    chk_byte("rst.out_data", bus.out_data, 8'h00);
    expect_beat("rst", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 expect_beat("rst_rel", 1'b0, 8'h00, 1'b0, 1'b1);

    // ---------------- basic full word ----------------
    @(negedge clk);
    drive(1'b1, w_a, 2'd3, 1'b1, 1'b1);
    #1 expect_beat("basic_acc", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1 expect_beat($sformatf("basic_b%0d", k), 1'b1, lane(w_a, k), (k == 3), (k == 3));
    end
    @(negedge clk);
    #1 expect_beat("basic_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // ---------------- back-to-back words ----------------
    @(negedge clk);
    drive(1'b1, w_a, 2'd3, 1'b0, 1'b1);
    #1 expect_beat("b2b_acc", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(1'b1, w_b, 2'd3, 1'b1, 1'b1);
      #1 expect_beat($sformatf("b2b_w0b%0d", k), 1'b1, lane(w_a, k), 1'b0, (k == 3));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1 expect_beat($sformatf("b2b_w1b%0d", k), 1'b1, lane(w_b, k), (k == 3), (k == 3));
    end
    @(negedge clk);
    #1 expect_beat("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // ---------------- backpressure on beat 1 ----------------
    @(negedge clk);
    drive(1'b1, w_a, 2'd3, 1'b1, 1'b1);
    #1 expect_beat("bp_acc", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    #1 expect_beat("bp_b0", 1'b1, lane(w_a, 0), 1'b0, 1'b0);
    // A competing word is offered during the stall; it must not be taken.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive(1'b1, 32'hCAFE_BABE, 2'd3, 1'b0, 1'b0);
      #1 expect_beat($sformatf("bp_stall%0d", s), 1'b1, lane(w_a, 1), 1'b0, 1'b0);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1 expect_beat($sformatf("bp_b%0d", k), 1'b1, lane(w_a, k), (k == 3), (k == 3));
    end
    @(negedge clk);
    #1 expect_beat("bp_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // ---------------- partial word, next word follows at once ----------------
    @(negedge clk);
    drive(1'b1, w_p, 2'd1, 1'b1, 1'b1);
    #1 expect_beat("part_acc", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, w_a, 2'd3, 1'b0, 1'b1);
    #1 expect_beat("part_b0", 1'b1, lane(w_p, 0), 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_beat("part_b1", 1'b1, lane(w_p, 1), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
      #1 expect_beat($sformatf("part_nxt%0d", k), 1'b1, lane(w_a, k), 1'b0, (k == 3));
    end
    @(negedge clk);
    #1 expect_beat("part_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // ---------------- asynchronous reset mid-word ----------------
    @(negedge clk);
    drive(1'b1, w_a, 2'd3, 1'b1, 1'b1);
    #1 expect_beat("rmw_acc", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    #1 expect_beat("rmw_b0", 1'b1, lane(w_a, 0), 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_beat("rmw_b1", 1'b1, lane(w_a, 1), 1'b0, 1'b0);
    @(negedge clk);
    #1 expect_beat("rmw_b2", 1'b1, lane(w_a, 2), 1'b0, 1'b0);
    // Assert reset between edges; outputs must clear before the next rise.
    #1 rst_n = 1'b0;
    #1;
    chk_byte("rmw_rst.out_data", bus.out_data, 8'h00);
    expect_beat("rmw_rst", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 expect_beat("rmw_rel", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    #1 expect_beat("rmw_nostale", 1'b0, 8'h00, 1'b0, 1'b1);

    // ---------------- single-beat word (in_cnt = 0) ----------------
    @(negedge clk);
    drive(1'b1, w_b, 2'd0, 1'b1, 1'b1);
    #1 expect_beat("one_acc", 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 2'd0, 1'b0, 1'b1);
    #1 expect_beat("one_b0", 1'b1, lane(w_b, 0), 1'b1, 1'b1);
    @(negedge clk);
    #1 expect_beat("one_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
